// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets, polarity constants and sync bundle type
package vga_pkg;

    localparam bit ACTIVE_LOW  = 1'b0;
    localparam bit ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_DISPLAY = 640;
    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_V_DISPLAY = 480;
    localparam int VGA640_V_BOTTOM  = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_TOP     = 33;
    localparam bit VGA640_HSYNC_POL = ACTIVE_LOW;
    localparam bit VGA640_VSYNC_POL = ACTIVE_LOW;

    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam int SVGA800_H_DISPLAY = 800;
    localparam int SVGA800_H_FRONT   = 56;
    localparam int SVGA800_H_SYNC    = 120;
    localparam int SVGA800_H_BACK    = 64;
    localparam int SVGA800_V_DISPLAY = 600;
    localparam int SVGA800_V_BOTTOM  = 37;
    localparam int SVGA800_V_SYNC    = 6;
    localparam int SVGA800_V_TOP     = 23;
    localparam bit SVGA800_HSYNC_POL = ACTIVE_HIGH;
    localparam bit SVGA800_VSYNC_POL = ACTIVE_HIGH;

    // 1024x768 @ 60 Hz, 65 MHz pixel clock
    localparam int XGA1024_H_DISPLAY = 1024;
    localparam int XGA1024_H_FRONT   = 24;
    localparam int XGA1024_H_SYNC    = 136;
    localparam int XGA1024_H_BACK    = 160;
    localparam int XGA1024_V_DISPLAY = 768;
    localparam int XGA1024_V_BOTTOM  = 3;
    localparam int XGA1024_V_SYNC    = 6;
    localparam int XGA1024_V_TOP     = 29;
    localparam bit XGA1024_HSYNC_POL = ACTIVE_LOW;
    localparam bit XGA1024_VSYNC_POL = ACTIVE_LOW;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
        logic line_start;
        logic frame_start;
    } vga_sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing generator control and raster outputs
interface vga_timing_gen_if #(
    parameter int HPOS_WIDTH  = 10,
    parameter int VPOS_WIDTH  = 10,
    parameter int FRAME_WIDTH = 8
);
    logic                   restart;
    logic                   pixel_en;
    logic                   hsync;
    logic                   vsync;
    logic                   display_on;
    logic [HPOS_WIDTH-1:0]  hpos;
    logic [VPOS_WIDTH-1:0]  vpos;
    logic                   line_start;
    logic                   frame_start;
    logic [FRAME_WIDTH-1:0] frame_count;

    modport master (
        input  restart,
        output pixel_en, hsync, vsync, display_on, hpos, vpos,
               line_start, frame_start, frame_count
    );

    modport slave (
        output restart,
        input  pixel_en, hsync, vsync, display_on, hpos, vpos,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with sync clear; depth 0 is a wire
module vga_delay_line #(
    parameter int               PIPE_DELAY = 0,
    parameter int               WIDTH      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (PIPE_DELAY == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset, en, clr};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [PIPE_DELAY];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= RESET_VAL;
            end else if (clr) begin
                for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= RESET_VAL;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[PIPE_DELAY-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing with divider, restart and output delay
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HPOS_WIDTH  = 10,
    parameter int VPOS_WIDTH  = 10,
    parameter int H_DISPLAY   = VGA640_H_DISPLAY,
    parameter int H_FRONT     = VGA640_H_FRONT,
    parameter int H_SYNC      = VGA640_H_SYNC,
    parameter int H_BACK      = VGA640_H_BACK,
    parameter int V_DISPLAY   = VGA640_V_DISPLAY,
    parameter int V_BOTTOM    = VGA640_V_BOTTOM,
    parameter int V_SYNC      = VGA640_V_SYNC,
    parameter int V_TOP       = VGA640_V_TOP,
    parameter int CLK_DIV     = 2,
    parameter bit HSYNC_POL   = ACTIVE_LOW,
    parameter bit VSYNC_POL   = ACTIVE_LOW,
    parameter int PIPE_DELAY  = 0,
    parameter int FRAME_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    vga_timing_gen_if.master   vif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int H_MAX   = H_TOTAL - 1;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int V_MAX   = V_TOTAL - 1;

    if (H_MAX >= (1 << HPOS_WIDTH)) begin : g_err_hpos
        $error("vga_timing_gen: H_MAX does not fit in HPOS_WIDTH");
    end
    if (V_MAX >= (1 << VPOS_WIDTH)) begin : g_err_vpos
        $error("vga_timing_gen: V_MAX does not fit in VPOS_WIDTH");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_err_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_err_pipe
        $error("vga_timing_gen: PIPE_DELAY must be 0..4");
    end

    localparam logic [HPOS_WIDTH-1:0] H_MAX_P  = HPOS_WIDTH'(H_MAX);
    localparam logic [HPOS_WIDTH-1:0] H_DISP_P = HPOS_WIDTH'(H_DISPLAY);
    localparam logic [HPOS_WIDTH-1:0] HS_BEG_P = HPOS_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [HPOS_WIDTH-1:0] HS_END_P = HPOS_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [VPOS_WIDTH-1:0] V_MAX_P  = VPOS_WIDTH'(V_MAX);
    localparam logic [VPOS_WIDTH-1:0] V_DISP_P = VPOS_WIDTH'(V_DISPLAY);
    localparam logic [VPOS_WIDTH-1:0] VS_BEG_P = VPOS_WIDTH'(V_DISPLAY + V_BOTTOM);
    localparam logic [VPOS_WIDTH-1:0] VS_END_P = VPOS_WIDTH'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [3:0]            DIV_LAST = 4'(CLK_DIV - 1);

    localparam vga_sync_t SYNC_IDLE = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        display_on:  1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    function automatic vga_sync_t decode(input logic [HPOS_WIDTH-1:0] h,
                                         input logic [VPOS_WIDTH-1:0] v);
        vga_sync_t s;
        s.hsync       = (h >= HS_BEG_P && h <= HS_END_P) ? HSYNC_POL : ~HSYNC_POL;
        s.vsync       = (v >= VS_BEG_P && v <= VS_END_P) ? VSYNC_POL : ~VSYNC_POL;
        s.display_on  = (h < H_DISP_P) && (v < V_DISP_P);
        s.line_start  = (h == '0);
        s.frame_start = (h == '0) && (v == '0);
        return s;
    endfunction

    logic [3:0]             div_q;
    logic                   pixel_en_q;
    logic [HPOS_WIDTH-1:0]  hpos_q;
    logic [VPOS_WIDTH-1:0]  vpos_q;
    logic [FRAME_WIDTH-1:0] frame_count_q;
    vga_sync_t              sync_q;
    vga_sync_t              sync_dly;

    logic [HPOS_WIDTH-1:0]  h_next;
    logic [VPOS_WIDTH-1:0]  v_next;
    logic                   frame_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            pixel_en_q <= 1'b0;
        end else if (vif.restart) begin
            div_q      <= '0;
            pixel_en_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q      <= '0;
            pixel_en_q <= 1'b1;
        end else begin
            div_q      <= div_q + 1'b1;
            pixel_en_q <= 1'b0;
        end
    end

    always_comb begin
        h_next     = hpos_q + 1'b1;
        v_next     = vpos_q;
        frame_wrap = 1'b0;
        if (hpos_q == H_MAX_P) begin
            h_next = '0;
            if (vpos_q == V_MAX_P) begin
                v_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                v_next = vpos_q + 1'b1;
            end
        end
    end

    // Sync/blank are decoded from the next position so they stay aligned with hpos/vpos.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_count_q <= '0;
            sync_q        <= SYNC_IDLE;
        end else if (vif.restart) begin
            hpos_q <= '0;
            vpos_q <= '0;
            sync_q <= decode('0, '0);
        end else if (pixel_en_q) begin
            hpos_q <= h_next;
            vpos_q <= v_next;
            sync_q <= decode(h_next, v_next);
            if (frame_wrap) frame_count_q <= frame_count_q + 1'b1;
        end
    end

    vga_delay_line #(
        .PIPE_DELAY (PIPE_DELAY),
        .WIDTH      ($bits(vga_sync_t)),
        .RESET_VAL  (SYNC_IDLE)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pixel_en_q),
        .clr   (vif.restart),
        .d     (sync_q),
        .q     (sync_dly)
    );

    assign vif.pixel_en    = pixel_en_q;
    assign vif.hsync       = sync_dly.hsync;
    assign vif.vsync       = sync_dly.vsync;
    assign vif.display_on  = sync_dly.display_on;
    assign vif.line_start  = sync_dly.line_start;
    assign vif.frame_start = sync_dly.frame_start;
    assign vif.hpos        = hpos_q;
    assign vif.vpos        = vpos_q;
    assign vif.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three parameter sets
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VD = 4, VB = 1, VSW = 2, VT = 1;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VTOT = VD + VB + VSW + VT;
    localparam int FP = HT * VTOT;

    typedef struct packed {
        logic        pe, hs, vs, de, ls, fs;
        logic [15:0] hpos, vpos, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .FRAME_WIDTH(8)) if0 ();
    vga_timing_gen_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .FRAME_WIDTH(8)) if1 ();
    vga_timing_gen_if #(.HPOS_WIDTH(4),  .VPOS_WIDTH(3),  .FRAME_WIDTH(2)) if2 ();
    assign if0.restart = restart;
    assign if1.restart = restart;
    assign if2.restart = restart;

    vga_timing_gen #(
        .HPOS_WIDTH(10), .VPOS_WIDTH(10), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VT), .CLK_DIV(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(0), .FRAME_WIDTH(8)
    ) u0 (.clk(clk), .reset(reset), .vif(if0));

    vga_timing_gen #(
        .HPOS_WIDTH(10), .VPOS_WIDTH(10), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VT), .CLK_DIV(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(3), .FRAME_WIDTH(8)
    ) u1 (.clk(clk), .reset(reset), .vif(if1));

    vga_timing_gen #(
        .HPOS_WIDTH(4), .VPOS_WIDTH(3), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VT), .CLK_DIV(16),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(4), .FRAME_WIDTH(2)
    ) u2 (.clk(clk), .reset(reset), .vif(if2));

    int DIVS [3] = '{2, 1, 16};
    int PDS  [3] = '{0, 3, 4};
    bit HPS  [3] = '{1'b0, 1'b1, 1'b0};
    bit VPS  [3] = '{1'b0, 1'b1, 1'b0};
    int FWS  [3] = '{8, 8, 2};

    int mc   [3];
    bit mrs  [3];
    int mfcb [3];

    exp_t sb [$];
    int   n_pass = 0;
    int   n_checks = 0;
    int   cyc = 0;

    function automatic int ticks(int k);
        return (mc[k] == 0) ? 0 : (mc[k] - 1) / DIVS[k];
    endfunction

    function automatic int cur_fc(int k);
        return (mfcb[k] + ticks(k) / FP) % (1 << FWS[k]);
    endfunction

    // Expected outputs derived from elapsed clocks since the last reset/restart.
    function automatic exp_t model(int k);
        exp_t e;
        int t, p, td, q, h, v;
        t      = ticks(k);
        p      = t % FP;
        e.pe   = (mc[k] > 0) && (mc[k] % DIVS[k] == 0);
        e.hpos = 16'(p % HT);
        e.vpos = 16'(p / HT);
        e.fc   = 16'(cur_fc(k));
        td     = t - PDS[k];
        if (td < 0 || (td == 0 && !mrs[k])) begin
            e.hs = ~HPS[k];
            e.vs = ~VPS[k];
            e.de = 1'b0;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end else begin
            q    = td % FP;
            h    = q % HT;
            v    = q / HT;
            e.hs = (h >= HD + HF && h <= HD + HF + HSW - 1) ? HPS[k] : ~HPS[k];
            e.vs = (v >= VD + VB && v <= VD + VB + VSW - 1) ? VPS[k] : ~VPS[k];
            e.de = (h < HD) && (v < VD);
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    function automatic exp_t observe(int k);
        exp_t o;
        case (k)
            0: o = '{if0.pixel_en, if0.hsync, if0.vsync, if0.display_on, if0.line_start,
                     if0.frame_start, 16'(if0.hpos), 16'(if0.vpos), 16'(if0.frame_count)};
            1: o = '{if1.pixel_en, if1.hsync, if1.vsync, if1.display_on, if1.line_start,
                     if1.frame_start, 16'(if1.hpos), 16'(if1.vpos), 16'(if1.frame_count)};
            default: o = '{if2.pixel_en, if2.hsync, if2.vsync, if2.display_on, if2.line_start,
                     if2.frame_start, 16'(if2.hpos), 16'(if2.vpos), 16'(if2.frame_count)};
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic push_model();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mc[k] = 0; mrs[k] = 1'b0; mfcb[k] = 0;
            end else if (restart) begin
                mfcb[k] = cur_fc(k); mc[k] = 0; mrs[k] = 1'b1;
            end else begin
                mc[k]++;
            end
            sb.push_back(model(k));
        end
    endtask

    task automatic pop_compare(input string what);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            chk($sformatf("%s_c%0d_u%0d", what, cyc, k), 64'(observe(k)), 64'(e));
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            push_model();
            @(posedge clk);
            @(negedge clk);
            cyc++;
            pop_compare("cyc");
        end
    endtask

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        step(3);
        chk("rst_hsync_lowpol", 64'(if0.hsync), 64'd1);
        chk("rst_hsync_highpol", 64'(if1.hsync), 64'd0);
        chk("rst_vsync_highpol", 64'(if1.vsync), 64'd0);
        reset = 1'b0;

        step(1300);
        chk("u0_fc_before_restart", 64'(if0.frame_count), 64'd5);

        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_hpos", 64'(if0.hpos), 64'd0);
        chk("restart_fc_kept", 64'(if0.frame_count), 64'd5);
        step(40);

        restart = 1'b1;
        step(4);
        restart = 1'b0;
        step(9700);
        chk("u2_fc_wrap", 64'(if2.frame_count), 64'd1);

        // Asynchronous reset between edges must take effect before the next posedge.
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            mc[k] = 0; mrs[k] = 1'b0; mfcb[k] = 0;
            sb.push_back(model(k));
        end
        pop_compare("async_rst");
        chk("async_rst_fc", 64'(if0.frame_count), 64'd0);
        @(negedge clk);
        step(2);
        reset = 1'b0;
        step(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor of the team's fixed 640x480 VGA sync generator.
- Produces registered hsync/vsync/display_on and hpos/vpos from a single system clock.
- Adds:
  - a programmable pixel-clock divider with an exported pixel_en strobe
  - selectable sync polarity
  - a configurable pipeline delay so sync/blank line up with a downstream pixel pipeline
  - line/frame markers, a frame counter and a synchronous restart
- Sits between the board clock and any pixel-generation logic (pattern generators, sprite engines, framebuffer readers).

Parameters:
- HPOS_WIDTH, 10, width of hpos
- VPOS_WIDTH, 10, width of vpos
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_BOTTOM, 10, vertical front porch
- V_SYNC, 2, vsync lines
- V_TOP, 33, vertical back porch
- CLK_DIV, 2, clk cycles per pixel (1..16)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIPE_DELAY, 0, pixel ticks of delay applied to sync/blank/marker outputs (0..4)
- FRAME_WIDTH, 8, width of frame_count

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- restart  input  1  synchronous resync request; 1-cycle pulse or level
- pixel_en  output  1  one-clk strobe marking each pixel tick
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- display_on  output  1  visible-area flag
- hpos  output  HPOS_WIDTH  current column
- vpos  output  VPOS_WIDTH  current line
- line_start  output  1  high while hpos==0
- frame_start  output  1  high while hpos==0 && vpos==0
- frame_count  output  FRAME_WIDTH  completed-frame counter

Interface decision (fixed): one clock, clk; reset is asynchronous and active-high, named reset.

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H parameters; H_MAX = H_TOTAL-1
  - V_TOTAL and V_MAX likewise
  - Elaboration error if H_MAX >= 2**HPOS_WIDTH, V_MAX >= 2**VPOS_WIDTH, CLK_DIV outside 1..16, or PIPE_DELAY > 4.
- Divider:
  - Counter div runs 0..CLK_DIV-1.
  - pixel_en = registered, high for one clk when div wraps.
  - CLK_DIV=1: pixel_en is high every cycle after reset.
- Position counters advance only on pixel_en:
  - hpos==H_MAX → hpos=0, and vpos wraps at V_MAX or otherwise increments.
  - Otherwise hpos increments and vpos holds.
- Output registration:
  - hsync/vsync/display_on/line_start/frame_start are computed from the next position and registered on the same pixel_en as hpos/vpos.
  - Undelayed, they therefore always describe the currently registered hpos/vpos.
- Sync windows:
  - hsync is active for H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1.
  - vsync uses the analogous V window.
  - display_on = hpos<H_DISPLAY && vpos<V_DISPLAY.
- PIPE_DELAY=N: hsync, vsync, display_on, line_start and frame_start pass through an N-stage shift register clocked by pixel_en. hpos/vpos are never delayed.
- frame_count increments, modulo 2**FRAME_WIDTH, on the pixel_en where the position wraps from (H_MAX,V_MAX) to (0,0).
- restart (synchronous, highest priority after reset):
  - On any clk with restart=1: div=0, hpos=0, vpos=0, and all delay stages are forced inactive. The undelayed output registers are set to the values for position (0,0), so PIPE_DELAY=0 shows them directly.
  - pixel_en=0 in the following cycle.
  - frame_count is not changed.
  - Held restart keeps the block parked at (0,0).
- Reset values:
  - div=0, pixel_en=0, hpos=0, vpos=0, frame_count=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL, display_on=0, line_start=0, frame_start=0
  - all delay stages inactive
  - The first frame after reset therefore shows pixel (0,0) blanked; this is accepted.
- Reset asserted mid-line returns all state to reset values immediately (asynchronous); counting resumes from (0,0) after deassertion.

Decomposition:
- Package vga_pkg holds preset localparam sets (640x480@60, 800x600@72, 1024x768@60) with their H_/V_ values, plus polarity constants ACTIVE_LOW/ACTIVE_HIGH.
- One sub-module: vga_delay_line. It is a PIPE_DELAY-deep, WIDTH-wide shift register with enable and synchronous clear, reset values supplied by parameter. PIPE_DELAY=0 is a wire-through.

Test Plan:
- Default params, reset 3 cycles then release:
  - pixel_en every 2nd clk
  - hpos sequence 1,2,…,799,0
  - hsync low exactly for hpos 656..751
  - vsync low for vpos 490..491
  - display_on low at hpos 640
- CLK_DIV=1, run 2 full frames (2×420000 clk): frame_count goes 0→1→2; frame_start high exactly at (0,0), once per frame.
- HSYNC_POL=1, VSYNC_POL=1: sync high only inside windows; reset value of both = 0.
- PIPE_DELAY=3: display_on falls 3 pixel ticks after hpos reaches 640; hsync asserts 3 ticks after hpos=656; hpos itself undelayed.
- restart pulsed at (hpos=300, vpos=200), frame_count=5:
  - next cycle hpos=0, vpos=0, frame_count=5
  - pixel_en resumes CLK_DIV cycles later
- Async reset asserted mid-frame, between clk edges: all outputs reach reset values before the next edge; frame_count=0.
